uart_tx_line_feeder: RTL and testbench



---
 rtl/uart_tx_line_feeder.sv | 111 +++++++++++
 tb/tb_uart_tx_line_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_line_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_line_feeder
// Brief    : Captures an ASCII line and feeds its leading bytes, byte 0 first,
//            into a UART TX FIFO over a valid/ready handshake.
//            Optional macro UART_TX_FEED_SKIP_NUL_EN drops 0x00 bytes.
// Revision : 1.0
// ============================================================================
module uart_tx_line_feeder #(
  parameter int LINE_BYTES = 34,
  parameter int LEN_BITS   = $clog2(LINE_BYTES + 1)
) (
  input  logic                    i_clk_20mhz,
  input  logic                    i_rst_20mhz_n,
  input  logic                    i_tx_go,
  input  logic [LINE_BYTES*8-1:0] i_dat_ascii_line,
  input  logic [LEN_BITS-1:0]     i_line_len,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int LINE_W = LINE_BYTES * 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CAPT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(LINE_BYTES);
  localparam logic [LEN_BITS-1:0] ONE_LEN = LEN_BITS'(1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [LEN_BITS-1:0] count;
  logic [LINE_W-1:0]   line_reg;
  logic [LEN_BITS-1:0] len_clamped;
  logic [7:0]          top_byte;
  logic                skip_byte;
  logic                accept;
  logic                advance;
  logic                last_byte;

  assign top_byte    = line_reg[LINE_W-1 -: 8];
  assign len_clamped = (i_line_len > MAX_LEN) ? MAX_LEN : i_line_len;

`ifdef UART_TX_FEED_SKIP_NUL_EN
  // A NUL at the head is consumed without offering it to the FIFO.
  assign skip_byte = (state == S_DATA) && (top_byte == 8'h00);
`else
  assign skip_byte = 1'b0;
`endif

  assign accept    = o_tx_valid && i_tx_ready;
  assign advance   = accept || skip_byte;
  assign last_byte = (count == ONE_LEN);

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_tx_go) state_nxt = S_CAPT;
      S_CAPT: state_nxt = (len_clamped == '0) ? S_DONE : S_DATA;
      S_DATA: if (advance && last_byte) state_nxt = S_DONE;
      S_DONE: state_nxt = S_WAIT;
      S_WAIT: if (!i_tx_go) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line register and remaining-byte counter; shift happens only on advance.
  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) begin
      line_reg <= {LINE_BYTES{8'h20}};
      count    <= '0;
    end else if (state == S_CAPT) begin
      line_reg <= i_dat_ascii_line;
      count    <= len_clamped;
    end else if ((state == S_DATA) && advance) begin
      line_reg <= {line_reg[LINE_W-9:0], 8'h00};
      count    <= count - ONE_LEN;
    end
  end

  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_done     = 1'b0;
    o_busy     = (state != S_IDLE);
    case (state)
      S_DATA: begin
        o_tx_valid = !skip_byte;
        o_tx_data  = top_byte;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_line_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_line_feeder
// Brief    : Scoreboard bench for uart_tx_line_feeder with directed and random lines.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_line_feeder;

  localparam int LB = 34;
  localparam int LW = LB * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic [LW-1:0] line_in = '0;
  logic [5:0]    len_in = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          ready = 1'b1;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;
  int accepted = 0;
  int pending_done = 0;
  logic [7:0] exp_q[$];

  uart_tx_line_feeder #(.LINE_BYTES(LB)) dut (
    .i_clk_20mhz      (clk),
    .i_rst_20mhz_n    (rst_n),
    .i_tx_go          (go),
    .i_dat_ascii_line (line_in),
    .i_line_len       (len_in),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .i_tx_ready       (ready),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #25 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [LW-1:0] l, input int i);
    return l[(LB-1-i)*8 +: 8];
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LB; i++) l[(LB-1-i)*8 +: 8] = 8'(32 + $urandom_range(0, 94));
    return l;
  endfunction

  // Ready generator: 0 = always high, 1 = random, 2 = repeating 1,0,0,1.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: ready = (ph == 1 || ph == 2) ? 1'b0 : 1'b1;
      endcase
      ph = (ph + 1) % 4;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid_held", int'(tx_valid), 1);
          chk("stall_data_held", int'(tx_data), int'(held));
        end
        if (!tx_valid) chk("idle_data_zero", int'(tx_data), 0);
        if (tx_valid && ready) begin
          accepted++;
          if (exp_q.size() == 0) chk("unexpected_byte", int'(tx_data), -1);
          else chk("byte", int'(tx_data), int'(exp_q.pop_front()));
        end
        stalled = tx_valid && !ready;
        held    = tx_data;
        if (done) begin
          chk("done_expected", int'(pending_done > 0), 1);
          if (pending_done > 0) pending_done--;
          chk("bytes_left_at_done", exp_q.size(), 0);
        end
      end
    end
  end

  // hold < 0: one-cycle go pulse; otherwise go stays high `hold` cycles past done.
  task automatic send_line(input logic [LW-1:0] l, input int len, input int mode, input int hold);
    int n, nexp, vcnt, cyc;
    logic first_valid, seen_done;
    n = (len > LB) ? LB : len;
    nexp = 0;
    for (int i = 0; i < n; i++) begin
`ifdef UART_TX_FEED_SKIP_NUL_EN
      if (byte_of(l, i) == 8'h00) continue;
`endif
      exp_q.push_back(byte_of(l, i));
      nexp++;
    end
    pending_done++;
`ifdef UART_TX_FEED_SKIP_NUL_EN
    first_valid = (n > 0) && (byte_of(l, 0) != 8'h00);
`else
    first_valid = (n > 0);
`endif
    cyc = 0;
    while (busy && cyc < 100) begin @(negedge clk); cyc++; end
    chk("idle_before_go", int'(busy), 0);
    @(posedge clk); #1;
    line_in = l; len_in = 6'(len); go = 1'b1; ready_mode = mode;
    @(posedge clk); #1;
    if (hold < 0) go = 1'b0;
    @(negedge clk);
    chk("capt_busy", int'(busy), 1);
    chk("capt_no_valid", int'(tx_valid), 0);
    @(negedge clk);
    if (n == 0) chk("len0_done_latency", int'(done), 1);
    else chk("first_valid_latency", int'(tx_valid), int'(first_valid));
    vcnt = int'(tx_valid);
    seen_done = done;
    line_in = rand_line(); len_in = 6'($urandom_range(0, 63));
    cyc = 0;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      vcnt += int'(tx_valid);
      seen_done = done;
      cyc++;
    end
    chk("done_seen", int'(seen_done), 1);
    if (!seen_done) begin exp_q.delete(); pending_done = 0; end
    if (mode == 0) chk("valid_cycles", vcnt, nexp);
    if (hold < 0) begin
      @(negedge clk); chk("wait_busy", int'(busy), 1);
      @(negedge clk); chk("idle_after_done", int'(busy), 0);
    end else begin
      repeat (hold) @(negedge clk);
      chk("held_go_busy", int'(busy), 1);
      @(posedge clk); #1; go = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("idle_after_go_low", int'(busy), 0);
    end
  endtask

  initial begin
    logic [LW-1:0] txt, nul_line;
    int cyc, start;
    txt = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345\r\n";
    nul_line = {8'h41, 8'h42, 256'h0};
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_line(txt, 34, 0, -1);
    send_line(txt, 34, 2, -1);
    send_line(rand_line(), 5, 0, -1);
    send_line(rand_line(), 0, 0, -1);
    send_line(rand_line(), 50, 1, -1);
    send_line(rand_line(), 34, 0, 200);

    // Reset in the middle of a line, then a fresh full line.
    exp_q.push_back(8'h00); exp_q.delete();
    for (int i = 0; i < LB; i++) exp_q.push_back(byte_of(txt, i));
    pending_done++;
    @(posedge clk); #1;
    line_in = txt; len_in = 6'd34; go = 1'b1; ready_mode = 0;
    @(posedge clk); #1; go = 1'b0;
    start = accepted; cyc = 0;
    while (accepted - start < 10 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reached_byte10", int'(accepted - start >= 10), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(tx_valid), 0);
    chk("midrst_data", int'(tx_data), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    exp_q.delete(); pending_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_line(rand_line(), 34, 0, -1);

    send_line(nul_line, 34, 0, -1);

    for (int k = 0; k < 20; k++)
      send_line(rand_line(), $urandom_range(0, 63), $urandom_range(0, 2),
                ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 5));

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("no_pending_done", pending_done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
